// File: rtl/bnn_axil_regfile.sv
// bnn_axil_regfile
//   AXI4-Lite slave register file sitting between the PS GP interconnect and
//   the BNN inference core.
//     reg0 CTRL   : bit0 START (self-clearing, reads 0), bit1 IRQ_EN
//     reg1 STATUS : bit0 BUSY (live core_busy), bit1 DONE (sticky, W1C)
//     reg2..      : general CFG registers, exported flat on cfg_regs
//
// Ports
//   S_AXI_ACLK, S_AXI_ARESET          clock, asynchronous active-high reset
//   S_AXI_AW* / S_AXI_W* / S_AXI_B*   write address, data and response channels
//   S_AXI_AR* / S_AXI_R*              read address and data channels
//   core_busy, core_done              status inputs from the core
//   start_pulse                       one-cycle start strobe to the core
//   irq                               level interrupt (DONE & IRQ_EN)
//   cfg_regs                          CFG registers, reg2 in the LSBs
module bnn_axil_regfile #(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 6,
    parameter int NUM_REGS           = 8
) (
    input  logic                                       S_AXI_ACLK,
    input  logic                                       S_AXI_ARESET,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]              S_AXI_AWADDR,
    input  logic [2:0]                                 S_AXI_AWPROT,
    input  logic                                       S_AXI_AWVALID,
    output logic                                       S_AXI_AWREADY,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]              S_AXI_WDATA,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0]            S_AXI_WSTRB,
    input  logic                                       S_AXI_WVALID,
    output logic                                       S_AXI_WREADY,
    output logic [1:0]                                 S_AXI_BRESP,
    output logic                                       S_AXI_BVALID,
    input  logic                                       S_AXI_BREADY,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]              S_AXI_ARADDR,
    input  logic [2:0]                                 S_AXI_ARPROT,
    input  logic                                       S_AXI_ARVALID,
    output logic                                       S_AXI_ARREADY,
    output logic [C_S_AXI_DATA_WIDTH-1:0]              S_AXI_RDATA,
    output logic [1:0]                                 S_AXI_RRESP,
    output logic                                       S_AXI_RVALID,
    input  logic                                       S_AXI_RREADY,
    input  logic                                       core_busy,
    input  logic                                       core_done,
    output logic                                       start_pulse,
    output logic                                       irq,
    output logic [(NUM_REGS-2)*C_S_AXI_DATA_WIDTH-1:0] cfg_regs
);

    localparam int DW       = C_S_AXI_DATA_WIDTH;
    localparam int SW       = DW / 8;
    localparam int ADDR_LSB = $clog2(SW);
    localparam int IDX_W    = C_S_AXI_ADDR_WIDTH - ADDR_LSB;
    localparam int NCFG     = NUM_REGS - 2;

    localparam logic [1:0]    RESP_OKAY   = 2'b00;
    localparam logic [1:0]    RESP_SLVERR = 2'b10;
    localparam logic [DW-1:0] DONE_MASK   = {{(DW-2){1'b0}}, 2'b10};

    // Expand byte strobes into a bit mask.
    function automatic logic [DW-1:0] strb_mask(input logic [SW-1:0] s);
        logic [DW-1:0] m;
        for (int b = 0; b < SW; b++) m[8*b +: 8] = {8{s[b]}};
        return m;
    endfunction

    // Protection bits and sub-word address bits carry no meaning here.
    logic unused_bits;
    assign unused_bits = ^{S_AXI_AWPROT, S_AXI_ARPROT,
                           S_AXI_AWADDR[ADDR_LSB-1:0], S_AXI_ARADDR[ADDR_LSB-1:0]};

    // State
    logic             active;          // low during reset and the first cycle after it
    logic             aw_full, w_full;
    logic [IDX_W-1:0] aw_idx;
    logic [DW-1:0]    w_data;
    logic [SW-1:0]    w_strb;
    logic             bvalid, rvalid;
    logic [1:0]       bresp, rresp;
    logic [DW-1:0]    rdata;
    logic             irq_en, done, start_q, irq_q;
    logic [DW-1:0]    cfg [NCFG];

    // Ready flags gated by 'active' so that they read 0 while reset is held.
    assign S_AXI_AWREADY = active & ~aw_full & ~bvalid;
    assign S_AXI_WREADY  = active & ~w_full & ~bvalid;
    assign S_AXI_ARREADY = active & ~rvalid;
    assign S_AXI_BVALID  = bvalid;
    assign S_AXI_BRESP   = bresp;
    assign S_AXI_RVALID  = rvalid;
    assign S_AXI_RRESP   = rresp;
    assign S_AXI_RDATA   = rdata;
    assign start_pulse   = start_q;
    assign irq           = irq_q;

    for (genvar g = 0; g < NCFG; g++) begin : g_cfg_out
        assign cfg_regs[g*DW +: DW] = cfg[g];
    end

    logic aw_hs, w_hs, ar_hs;
    assign aw_hs = S_AXI_AWVALID & S_AXI_AWREADY;
    assign w_hs  = S_AXI_WVALID  & S_AXI_WREADY;
    assign ar_hs = S_AXI_ARVALID & S_AXI_ARREADY;

    // Commit decode: fires on the cycle after both holders are full.
    logic          commit, wr_err, bad_idx, bad_status, wr_ok;
    logic          ctrl_wr, w1c;
    logic [DW-1:0] wmask, wbits;

    always_comb begin
        commit     = aw_full & w_full & ~bvalid;
        wmask      = strb_mask(w_strb);
        wbits      = w_data & wmask;
        bad_idx    = int'(aw_idx) >= NUM_REGS;
        // Only DONE is writable in STATUS; any other strobed 1 is rejected.
        bad_status = (int'(aw_idx) == 1) && ((wbits & ~DONE_MASK) != '0);
        wr_err     = bad_idx | bad_status;
        wr_ok      = commit & ~wr_err;
        ctrl_wr    = wr_ok & (int'(aw_idx) == 0) & w_strb[0];
        w1c        = wr_ok & (int'(aw_idx) == 1) & w_strb[0] & w_data[1];
    end

    // Read mux; BUSY is the live core level at the moment of capture.
    logic [IDX_W-1:0] ar_idx;
    logic [DW-1:0]    rd_val;
    logic             rd_err;

    assign ar_idx = S_AXI_ARADDR[C_S_AXI_ADDR_WIDTH-1:ADDR_LSB];

    always_comb begin
        rd_val = '0;
        rd_err = 1'b0;
        if (int'(ar_idx) >= NUM_REGS) begin
            rd_err = 1'b1;
        end else if (int'(ar_idx) == 0) begin
            rd_val[1] = irq_en;
        end else if (int'(ar_idx) == 1) begin
            rd_val[0] = core_busy;
            rd_val[1] = done;
        end else begin
            for (int i = 0; i < NCFG; i++)
                if (int'(ar_idx) == i + 2) rd_val = cfg[i];
        end
    end

    always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
        if (S_AXI_ARESET) begin
            active  <= 1'b0;
            aw_full <= 1'b0;
            w_full  <= 1'b0;
            aw_idx  <= '0;
            w_data  <= '0;
            w_strb  <= '0;
            bvalid  <= 1'b0;
            bresp   <= RESP_OKAY;
            rvalid  <= 1'b0;
            rresp   <= RESP_OKAY;
            rdata   <= '0;
            irq_en  <= 1'b0;
            done    <= 1'b0;
            start_q <= 1'b0;
            irq_q   <= 1'b0;
            for (int i = 0; i < NCFG; i++) cfg[i] <= '0;
        end else begin
            active <= 1'b1;

            if (aw_hs) begin
                aw_full <= 1'b1;
                aw_idx  <= S_AXI_AWADDR[C_S_AXI_ADDR_WIDTH-1:ADDR_LSB];
            end
            if (w_hs) begin
                w_full <= 1'b1;
                w_data <= S_AXI_WDATA;
                w_strb <= S_AXI_WSTRB;
            end

            // Holders cannot be accepting while commit is pending, so the
            // clears below never collide with a capture above.
            if (commit) begin
                aw_full <= 1'b0;
                w_full  <= 1'b0;
                bvalid  <= 1'b1;
                bresp   <= wr_err ? RESP_SLVERR : RESP_OKAY;
            end else if (bvalid && S_AXI_BREADY) begin
                bvalid <= 1'b0;
            end

            if (ctrl_wr) irq_en <= w_data[1];
            start_q <= ctrl_wr & w_data[0];

            for (int i = 0; i < NCFG; i++)
                if (wr_ok && int'(aw_idx) == i + 2)
                    cfg[i] <= (cfg[i] & ~wmask) | wbits;

            // A completion arriving with the W1C commit keeps DONE set.
            done  <= core_done | (done & ~w1c);
            irq_q <= done & irq_en;

            if (ar_hs) begin
                rvalid <= 1'b1;
                rdata  <= rd_val;
                rresp  <= rd_err ? RESP_SLVERR : RESP_OKAY;
            end else if (rvalid && S_AXI_RREADY) begin
                rvalid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_bnn_axil_regfile.sv
module tb_bnn_axil_regfile;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [5:0]  AWADDR = '0;
    logic [2:0]  AWPROT = '0;
    logic        AWVALID = 1'b0;
    logic        AWREADY;
    logic [31:0] WDATA = '0;
    logic [3:0]  WSTRB = '0;
    logic        WVALID = 1'b0;
    logic        WREADY;
    logic [1:0]  BRESP;
    logic        BVALID;
    logic        BREADY = 1'b0;
    logic [5:0]  ARADDR = '0;
    logic [2:0]  ARPROT = '0;
    logic        ARVALID = 1'b0;
    logic        ARREADY;
    logic [31:0] RDATA;
    logic [1:0]  RRESP;
    logic        RVALID;
    logic        RREADY = 1'b0;
    logic        core_busy = 1'b0;
    logic        core_done = 1'b0;
    logic        start_pulse;
    logic        irq;
    logic [191:0] cfg_regs;

    always #5 clk = ~clk;

    bnn_axil_regfile dut (
        .S_AXI_ACLK(clk), .S_AXI_ARESET(rst),
        .S_AXI_AWADDR(AWADDR), .S_AXI_AWPROT(AWPROT), .S_AXI_AWVALID(AWVALID), .S_AXI_AWREADY(AWREADY),
        .S_AXI_WDATA(WDATA), .S_AXI_WSTRB(WSTRB), .S_AXI_WVALID(WVALID), .S_AXI_WREADY(WREADY),
        .S_AXI_BRESP(BRESP), .S_AXI_BVALID(BVALID), .S_AXI_BREADY(BREADY),
        .S_AXI_ARADDR(ARADDR), .S_AXI_ARPROT(ARPROT), .S_AXI_ARVALID(ARVALID), .S_AXI_ARREADY(ARREADY),
        .S_AXI_RDATA(RDATA), .S_AXI_RRESP(RRESP), .S_AXI_RVALID(RVALID), .S_AXI_RREADY(RREADY),
        .core_busy(core_busy), .core_done(core_done), .start_pulse(start_pulse), .irq(irq),
        .cfg_regs(cfg_regs)
    );

    int vectors = 0;
    int miscompares = 0;

    // Reference model: register contents as the software would see them.
    logic [31:0] m_reg [8];
    logic        m_done, m_irq_en;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic void model_reset();
        for (int i = 0; i < 8; i++) m_reg[i] = '0;
        m_done = 1'b0;
        m_irq_en = 1'b0;
    endfunction

    // Applies a write to the model and returns the expected BRESP.
    function automatic logic [1:0] model_write(input int idx, input logic [31:0] d, input logic [3:0] s);
        logic [31:0] m;
        for (int b = 0; b < 4; b++) m[8*b +: 8] = {8{s[b]}};
        if (idx >= 8) return 2'b10;
        if (idx == 1) begin
            if ((d & m & ~32'h2) != 0) return 2'b10;
            if (s[0] && d[1]) m_done = 1'b0;
            return 2'b00;
        end
        if (idx == 0) begin
            if (s[0]) m_irq_en = d[1];
            return 2'b00;
        end
        m_reg[idx] = (m_reg[idx] & ~m) | (d & m);
        return 2'b00;
    endfunction

    function automatic void model_read(input int idx, input logic busy,
                                       output logic [31:0] d, output logic [1:0] r);
        d = '0;
        r = 2'b00;
        if (idx >= 8)      r = 2'b10;
        else if (idx == 0) d = {30'b0, m_irq_en, 1'b0};
        else if (idx == 1) d = {30'b0, m_done, busy};
        else               d = m_reg[idx];
    endfunction

    task automatic axi_write(input logic [5:0] addr, input logic [31:0] data, input logic [3:0] strb,
                             output logic [1:0] resp, output logic start_seen);
        int n = 0;
        logic aw_done = 1'b0, w_done = 1'b0, aw_take, w_take;
        AWADDR = addr; WDATA = data; WSTRB = strb; AWVALID = 1'b1; WVALID = 1'b1;
        while (!(aw_done && w_done) && n < 40) begin
            aw_take = AWVALID && AWREADY;
            w_take  = WVALID && WREADY;
            @(posedge clk); #1;
            if (aw_take) begin AWVALID = 1'b0; aw_done = 1'b1; end
            if (w_take)  begin WVALID = 1'b0;  w_done = 1'b1;  end
            n++;
        end
        BREADY = 1'b1;
        while (!BVALID && n < 40) begin @(posedge clk); #1; n++; end
        if (n >= 40) begin
            chk("wr_timeout", 1, 0);
            AWVALID = 1'b0; WVALID = 1'b0;
            resp = 2'b11; start_seen = 1'b0;
        end else begin
            resp = BRESP;
            start_seen = start_pulse;
            @(posedge clk); #1;
        end
        BREADY = 1'b0;
    endtask

    task automatic axi_read(input logic [5:0] addr, output logic [31:0] data, output logic [1:0] resp);
        int n = 0;
        logic take = 1'b0;
        ARADDR = addr; ARVALID = 1'b1;
        while (!take && n < 40) begin
            take = ARREADY;
            @(posedge clk); #1;
            n++;
        end
        ARVALID = 1'b0;
        RREADY = 1'b1;
        while (!RVALID && n < 40) begin @(posedge clk); #1; n++; end
        if (n >= 40) begin
            chk("rd_timeout", 1, 0);
            data = 'x; resp = 2'b11;
        end else begin
            data = RDATA; resp = RRESP;
            @(posedge clk); #1;
        end
        RREADY = 1'b0;
    endtask

    task automatic do_write(input logic [5:0] addr, input logic [31:0] data, input logic [3:0] strb);
        logic [1:0] resp, eresp;
        logic st;
        int idx = int'(addr[5:2]);
        axi_write(addr, data, strb, resp, st);
        eresp = model_write(idx, data, strb);
        chk("bresp", resp, eresp);
        chk("start_pulse", st, (eresp == 2'b00 && idx == 0 && strb[0] && data[0]));
        chk("start_off", start_pulse, 0);
    endtask

    task automatic do_read(input logic [5:0] addr);
        logic [31:0] d, ed;
        logic [1:0]  r, er;
        logic busy = 1'($urandom_range(0, 1));
        core_busy = busy;
        axi_read(addr, d, r);
        model_read(int'(addr[5:2]), busy, ed, er);
        chk("rdata", d, ed);
        chk("rresp", r, er);
    endtask

    task automatic chk_cfg();
        for (int i = 0; i < 6; i++) chk("cfg_regs", cfg_regs[i*32 +: 32], m_reg[i+2]);
    endtask

    task automatic pulse_done();
        core_done = 1'b1;
        @(posedge clk); #1;
        core_done = 1'b0;
        m_done = 1'b1;
    endtask

    initial begin
        logic [31:0] d;
        logic [1:0]  r, e;
        int idx;

        model_reset();
        repeat (3) @(posedge clk);
        #1;
        chk("rst_awready", AWREADY, 0);
        chk("rst_wready", WREADY, 0);
        chk("rst_arready", ARREADY, 0);
        chk("rst_bvalid", BVALID, 0);
        chk("rst_rvalid", RVALID, 0);
        chk("rst_bresp", BRESP, 0);
        chk("rst_rresp", RRESP, 0);
        chk("rst_rdata", RDATA, 0);
        chk("rst_start", start_pulse, 0);
        chk("rst_irq", irq, 0);
        chk_cfg();
        rst = 1'b0;
        @(posedge clk); #1;

        // Basic CFG writes and readback
        for (int i = 0; i < 6; i++) do_write(6'(8 + 4*i), 32'(i + 1), 4'hF);
        for (int i = 0; i < 6; i++) begin
            axi_read(6'(8 + 4*i), d, r);
            chk("t1_rdata", d, 32'(i + 1));
            chk("t1_rresp", r, 2'b00);
        end
        chk("t1_cfg_lsb", cfg_regs[31:0], 32'h1);

        // W three cycles ahead of AW, then AW+W together while B is held
        WDATA = 32'h0000_00A5; WSTRB = 4'hF; WVALID = 1'b1;
        chk("t2_wready", WREADY, 1);
        @(posedge clk); #1;
        WVALID = 1'b0;
        chk("t2_wheld", WREADY, 0);
        repeat (2) begin @(posedge clk); #1; end
        AWADDR = 6'h0C; AWVALID = 1'b1;
        chk("t2_awready", AWREADY, 1);
        @(posedge clk); #1;
        AWVALID = 1'b0;
        chk("t2_bv_early", BVALID, 0);
        @(posedge clk); #1;
        chk("t2_bv_rise", BVALID, 1);
        e = model_write(3, 32'hA5, 4'hF);
        AWADDR = 6'h10; AWVALID = 1'b1; WDATA = 32'h0000_005A; WVALID = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk("t2_hold_awready", AWREADY, 0);
            chk("t2_hold_wready", WREADY, 0);
            chk("t2_hold_bvalid", BVALID, 1);
            chk("t2_hold_bresp", BRESP, e);
            @(posedge clk); #1;
        end
        BREADY = 1'b1;
        @(posedge clk); #1;
        BREADY = 1'b0;
        chk("t2_b_done", BVALID, 0);
        chk("t2_awready2", AWREADY, 1);
        chk("t2_wready2", WREADY, 1);
        @(posedge clk); #1;
        AWVALID = 1'b0; WVALID = 1'b0;
        chk("t2_bv_early2", BVALID, 0);
        chk("t2_awfull2", AWREADY, 0);
        @(posedge clk); #1;
        chk("t2_bv_rise2", BVALID, 1);
        e = model_write(4, 32'h5A, 4'hF);
        chk("t2_bresp2", BRESP, e);
        BREADY = 1'b1;
        @(posedge clk); #1;
        BREADY = 1'b0;
        do_read(6'h0C);
        do_read(6'h10);

        // Byte strobes
        do_write(6'h08, 32'hAABB_CCDD, 4'hF);
        do_write(6'h08, 32'h1122_3344, 4'b0101);
        axi_read(6'h08, d, r);
        chk("t3_merge", d, 32'hAA22_CC44);
        chk("t3_model", d, m_reg[2]);

        // CTRL start, DONE/irq, W1C
        do_write(6'h00, 32'h3, 4'hF);
        axi_read(6'h00, d, r);
        chk("t4_ctrl_rd", d, 32'h2);
        core_done = 1'b1;
        @(posedge clk); #1;
        core_done = 1'b0;
        m_done = 1'b1;
        chk("t4_irq_lag", irq, 0);
        @(posedge clk); #1;
        chk("t4_irq_set", irq, 1);
        do_read(6'h04);
        do_write(6'h04, 32'h2, 4'hF);
        @(posedge clk); #1;
        chk("t4_irq_clr", irq, 0);
        do_read(6'h04);

        // core_done coincident with the W1C commit
        pulse_done();
        AWADDR = 6'h04; WDATA = 32'h2; WSTRB = 4'hF; AWVALID = 1'b1; WVALID = 1'b1;
        chk("t5_ready", {AWREADY, WREADY}, 2'b11);
        @(posedge clk); #1;
        AWVALID = 1'b0; WVALID = 1'b0;
        core_done = 1'b1;
        @(posedge clk); #1;
        core_done = 1'b0;
        chk("t5_bvalid", BVALID, 1);
        chk("t5_bresp", BRESP, 0);
        BREADY = 1'b1;
        @(posedge clk); #1;
        BREADY = 1'b0;
        do_read(6'h04);
        chk("t5_irq", irq, 1);

        // Randomized traffic
        for (int n = 0; n < 150; n++) begin
            int op = $urandom_range(0, 9);
            idx = ($urandom_range(0, 4) == 0) ? $urandom_range(8, 15) : $urandom_range(0, 7);
            if (op < 5) begin
                d = $urandom;
                if (idx == 1) begin
                    case ($urandom_range(0, 3))
                        0: d = 32'h2;
                        1: d = 32'h1;
                        2: d = 32'h0;
                        default: d = $urandom;
                    endcase
                end
                do_write({4'(idx), 2'($urandom_range(0, 3))}, d, 4'($urandom_range(0, 15)));
                chk_cfg();
            end else if (op < 9) begin
                do_read({4'(idx), 2'($urandom_range(0, 3))});
            end else begin
                pulse_done();
                @(posedge clk); #1;
            end
            chk("rnd_irq", irq, m_done & m_irq_en);
        end

        // Error responses
        do_write(6'h20, 32'hDEAD_BEEF, 4'hF);
        do_write(6'h3C, 32'h1234_5678, 4'hF);
        axi_read(6'h20, d, r);
        chk("t6_rd_oob_data", d, 0);
        chk("t6_rd_oob_resp", r, 2'b10);
        do_write(6'h04, 32'h1, 4'hF);
        for (int i = 0; i < 16; i++) do_read(6'(4*i));
        chk_cfg();

        // Reset while a read response is pending
        ARADDR = 6'h08; ARVALID = 1'b1;
        chk("t6_arready", ARREADY, 1);
        @(posedge clk); #1;
        ARVALID = 1'b0;
        chk("t6_rvalid_pend", RVALID, 1);
        rst = 1'b1;
        #1;
        chk("t6_rvalid_rst", RVALID, 0);
        chk("t6_rdata_rst", RDATA, 0);
        chk("t6_irq_rst", irq, 0);
        model_reset();
        chk_cfg();
        @(posedge clk); #1;
        rst = 1'b0;
        RREADY = 1'b1;
        repeat (3) begin
            @(posedge clk); #1;
            chk("t6_no_resp", RVALID, 0);
        end
        RREADY = 1'b0;
        do_read(6'h08);
        do_read(6'h00);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/bnn_axil_regfile.md
Name: bnn_axil_regfile

Overview:
- Parametrised AXI4-Lite slave register file. It is the next generation of the fixed 4-register bnn_v1_0 slave interface.
- Adds the following over the fixed block:
  - configurable register count and data width
  - byte strobes
  - a control register with a self-clearing START bit
  - a read-only/W1C status register fed by the BNN core
  - SLVERR responses
  - a level interrupt
- Sits between the PS AXI interconnect (GP port) and the BNN inference core.

Parameters:
- C_S_AXI_DATA_WIDTH, 32, data bus width; legal values 32 or 64.
- C_S_AXI_ADDR_WIDTH, 6, byte address width; must satisfy 2^ADDR_WIDTH >= NUM_REGS*DATA_WIDTH/8.
- NUM_REGS, 8, total register count, at least 3.
  - reg0 is CTRL.
  - reg1 is STATUS.
  - reg2 to reg(NUM_REGS-1) are general CFG registers.
- ADDR_LSB, derived as clog2(DATA_WIDTH/8); word index is addr[ADDR_WIDTH-1:ADDR_LSB].

Ports:
- S_AXI_ACLK  in  1  clock
- S_AXI_ARESET  in  1  asynchronous, active-high reset
- S_AXI_AWADDR  in  ADDR_WIDTH  write address
- S_AXI_AWPROT  in  3  ignored
- S_AXI_AWVALID / S_AXI_AWREADY  in / out  1  write address handshake
- S_AXI_WDATA  in  DATA_WIDTH  write data
- S_AXI_WSTRB  in  DATA_WIDTH/8  byte enables
- S_AXI_WVALID / S_AXI_WREADY  in / out  1  write data handshake
- S_AXI_BRESP  out  2  write response; 00 OKAY, 10 SLVERR
- S_AXI_BVALID / S_AXI_BREADY  out / in  1  write response handshake
- S_AXI_ARADDR  in  ADDR_WIDTH  read address
- S_AXI_ARPROT  in  3  ignored
- S_AXI_ARVALID / S_AXI_ARREADY  in / out  1  read address handshake
- S_AXI_RDATA  out  DATA_WIDTH  read data
- S_AXI_RRESP  out  2  read response
- S_AXI_RVALID / S_AXI_RREADY  out / in  1  read data handshake
- core_busy  in  1  live busy level from the core
- core_done  in  1  single-cycle completion pulse from the core
- start_pulse  out  1  single-cycle start strobe to the core
- irq  out  1  level interrupt
- cfg_regs  out  (NUM_REGS-2)*DATA_WIDTH  flat concatenation of the CFG registers; reg2 occupies the LSBs

Behaviour:
- Reset (async assert, sync deassert by the system):
  - all handshake outputs (AWREADY, WREADY, BVALID, ARREADY, RVALID) = 0
  - BRESP = RRESP = 00, RDATA = 0
  - all registers = 0
  - start_pulse = irq = 0
- Reset asserted mid-transaction aborts it; no response is issued after release.
- Write path: AW and W are captured independently into single-entry holding registers, and may arrive in either order or in the same cycle.
  - AWREADY = 1 while the AW holder is empty and BVALID = 0.
  - WREADY = 1 while the W holder is empty and BVALID = 0.
- Commit happens on the cycle after both holders are full. On that edge:
  - the register update is applied
  - BVALID rises
  - both holders clear
- BVALID is held, with BRESP stable, until BREADY. The earliest next AW/W acceptance is the cycle after the B handshake.
- Byte strobes: only bytes with WSTRB=1 are updated; WSTRB=0 for all bytes is a legal no-op that returns OKAY.
- SLVERR conditions (no state change in either case):
  - word index >= NUM_REGS
  - write to STATUS with any bit set other than DONE
- CTRL register (reg0):
  - bit0 START: writing 1 with strobe byte0 makes start_pulse = 1 on the cycle following the commit, for exactly one cycle. START always reads back 0.
  - bit1 IRQ_EN: read/write.
  - Other bits are reserved, read 0, and writes to them are ignored.
- STATUS register (reg1):
  - bit0 BUSY = core_busy, sampled when the read data is captured; read-only.
  - bit1 DONE: sticky; set by core_done, cleared by writing 1 (W1C).
  - If core_done coincides with the W1C commit, set wins and DONE stays 1.
- irq is registered: irq = DONE & IRQ_EN, one cycle after either bit changes.
- Read path:
  - ARREADY = 1 while RVALID = 0.
  - After an AR handshake, RVALID = 1 on the next cycle, with RDATA and RRESP registered at that edge.
  - RVALID, RDATA and RRESP are held until RREADY.
  - Out-of-range read returns RDATA = 0 with RRESP = SLVERR.
- Simultaneous read and write to the same register: the read returns the pre-commit value if the AR handshake precedes or coincides with the commit edge.
- Read and write channels are fully independent; at most one transaction is outstanding per direction.

Test Plan:
1. Reset release, then write 0x00000001..0x00000006 to reg2..reg7 (addresses 0x08..0x1C), read back each -> OKAY with matching data; cfg_regs[31:0] = 0x00000001.
2. W presented 3 cycles before AW, and also both in the same cycle -> one commit each; BVALID rises one cycle after the later handshake; hold BREADY low 4 cycles -> AWREADY/WREADY stay 0 and BRESP stays stable.
3. Write reg2 = 0xAABBCCDD, then 0x11223344 with WSTRB = 0101 -> reads 0xAA22CC44.
4. Write CTRL = 0x3 -> start_pulse high exactly one cycle; CTRL reads 0x2; pulse core_done -> STATUS.DONE = 1 and irq = 1 the next cycle; W1C 0x2 -> irq drops.
5. Assert core_done in the same cycle as the W1C commit -> DONE remains 1.
6. Write to 0x20 and 0x3C, read 0x20, write STATUS = 0x1 -> BRESP = 10 / RRESP = 10 with RDATA = 0, no register changes; assert reset while RVALID is pending -> RVALID = 0 immediately.
